// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  // Registered controller state; encodings are visible on the state output.
  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2,
    StBrFlush   = 2'd3
  } hz_state_e;

  localparam int unsigned MemTimeoutDefault = 255;

  // Saturating increment for the 16-bit status counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources from the pipeline and control/status back to it.
interface pipeline_hazard_ctrl_if;
  // ID / EX hazard sources
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       idex_MemRead;
  logic [4:0] idex_reg_dest;
  // MEM-stage controls
  logic       exmem_Branch;
  logic       exmem_zero;
  logic       exmem_MemRead;
  logic       exmem_MemWrite;
  logic       mem_ready;
  // Pipeline register enables and flushes
  logic       pc_write;
  logic       ifid_write;
  logic       idex_write;
  logic       exmem_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       pc_src_branch;
  // Status
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic        mem_timeout;

  // Pipeline side: drives hazard sources, receives control.
  modport master (
    output id_rs, id_rt, id_uses_rt, idex_MemRead, idex_reg_dest,
    output exmem_Branch, exmem_zero, exmem_MemRead, exmem_MemWrite, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write,
    input  ifid_flush, idex_flush, exmem_flush, pc_src_branch,
    input  state, stall_count, flush_count, mem_timeout
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_MemRead, idex_reg_dest,
    input  exmem_Branch, exmem_zero, exmem_MemRead, exmem_MemWrite, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write,
    output ifid_flush, idex_flush, exmem_flush, pc_src_branch,
    output state, stall_count, flush_count, mem_timeout
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: EX-stage load writes a register the ID instruction reads.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_reg_dest,
  output logic       load_use
);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  always_comb begin
    load_use = idex_mem_read && (idex_reg_dest != 5'd0) &&
               ((idex_reg_dest == id_rs) || (id_uses_rt && (idex_reg_dest == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freezes on memory waits, flushes on taken branches,
// inserts a one-cycle bubble on load-use, and keeps stall/flush statistics.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
) (
  input logic                 clock,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [15:0] TimeoutCnt = 16'(MEM_TIMEOUT);

  hz_state_e   state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  logic mem_busy, taken, load_use, load_use_eff;

  hazard_detect u_hazard_detect (
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_uses_rt    (bus.id_uses_rt),
    .idex_mem_read (bus.idex_MemRead),
    .idex_reg_dest (bus.idex_reg_dest),
    .load_use      (load_use)
  );

  assign mem_busy = (bus.exmem_MemRead | bus.exmem_MemWrite) & ~bus.mem_ready;
  assign taken    = bus.exmem_Branch & bus.exmem_zero;
  // A bubble or squashed instruction now sits in ID/EX, so the hazard is stale.
  assign load_use_eff = load_use && (state_q != StLoadStall) && (state_q != StBrFlush);

  // Next-state, Mealy control outputs and counter updates.
  always_comb begin
    state_d           = StRun;
    stall_cnt_d       = stall_cnt_q;
    flush_cnt_d       = flush_cnt_q;
    wait_cnt_d        = 16'd0;
    timeout_d         = timeout_q;
    bus.pc_write      = 1'b1;
    bus.ifid_write    = 1'b1;
    bus.idex_write    = 1'b1;
    bus.exmem_write   = 1'b1;
    bus.ifid_flush    = 1'b0;
    bus.idex_flush    = 1'b0;
    bus.exmem_flush   = 1'b0;
    bus.pc_src_branch = 1'b0;

    if (reset) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_write  = 1'b0;
      bus.exmem_write = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end else if (mem_busy) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_write  = 1'b0;
      bus.exmem_write = 1'b0;
      state_d         = StMemWait;
      stall_cnt_d     = sat_inc(stall_cnt_q);
      wait_cnt_d      = sat_inc(wait_cnt_q);
      if (wait_cnt_d >= TimeoutCnt) timeout_d = 1'b1;
    end else if (taken) begin
      bus.ifid_flush    = 1'b1;
      bus.idex_flush    = 1'b1;
      bus.exmem_flush   = 1'b1;
      bus.pc_src_branch = 1'b1;
      state_d           = StBrFlush;
      flush_cnt_d       = sat_inc(flush_cnt_q);
    end else if (load_use_eff) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.idex_flush = 1'b1;
      state_d        = StLoadStall;
      stall_cnt_d    = sat_inc(stall_cnt_q);
    end
  end

  // State and counter registers; reset discards any update in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      wait_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // {pc, ifid, idex, exmem} enables and {ifid, idex, exmem} flushes
  wire [3:0] en = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write};
  wire [2:0] fl = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic ld, input logic [4:0] dest, input logic br,
                       input logic zero, input logic mrd, input logic mwr,
                       input logic ready);
    bus.id_rs          = rs;
    bus.id_rt          = rt;
    bus.id_uses_rt     = uses_rt;
    bus.idex_MemRead   = ld;
    bus.idex_reg_dest  = dest;
    bus.exmem_Branch   = br;
    bus.exmem_zero     = zero;
    bus.exmem_MemRead  = mrd;
    bus.exmem_MemWrite = mwr;
    bus.mem_ready      = ready;
    #1;
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [3:0] e, input logic [2:0] f,
                            input logic pcs);
    check({tag, "_en"}, 32'(en), 32'(e));
    check({tag, "_fl"}, 32'(fl), 32'(f));
    check({tag, "_pcs"}, 32'(bus.pc_src_branch), 32'(pcs));
  endtask

  task automatic check_stat(input string tag, input logic [1:0] st, input logic [15:0] sc,
                            input logic [15:0] fc, input logic to);
    check({tag, "_state"}, 32'(bus.state), 32'(st));
    check({tag, "_stall"}, 32'(bus.stall_count), 32'(sc));
    check({tag, "_flush"}, 32'(bus.flush_count), 32'(fc));
    check({tag, "_tmo"}, 32'(bus.mem_timeout), 32'(to));
  endtask

  initial begin
    // Reset held: everything frozen and flushed.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("rst_ctrl", 4'b0000, 3'b111, 1'b0);
    tick();
    check_stat("rst_stat", 2'd0, 16'd0, 16'd0, 1'b0);
    reset = 1'b0;

    // Quiet pipeline.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("normal", 4'b1111, 3'b000, 1'b0);
    tick();
    check_stat("normal", 2'd0, 16'd0, 16'd0, 1'b0);

    // Load-use on rs: one bubble, then the held hazard is ignored.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("lu_rs", 4'b0011, 3'b010, 1'b0);
    tick();
    check_stat("lu_rs", 2'd1, 16'd1, 16'd0, 1'b0);
    check_ctrl("lu_rs_held", 4'b1111, 3'b000, 1'b0);
    tick();
    check_stat("lu_rs_done", 2'd0, 16'd1, 16'd0, 1'b0);

    // Load into r0 is never a hazard.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("lu_r0", 4'b1111, 3'b000, 1'b0);
    tick();
    check_stat("lu_r0", 2'd0, 16'd1, 16'd0, 1'b0);

    // rt match only counts when the instruction reads rt.
    drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("lu_rt_unused", 4'b1111, 3'b000, 1'b0);
    drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("lu_rt", 4'b0011, 3'b010, 1'b0);
    tick();
    check_stat("lu_rt", 2'd1, 16'd2, 16'd0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Taken branch beats load-use; load-use in BR_FLUSH is ignored.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_ctrl("taken", 4'b1111, 3'b111, 1'b1);
    tick();
    check_stat("taken", 2'd3, 16'd2, 16'd1, 1'b0);
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("brflush_lu", 4'b1111, 3'b000, 1'b0);
    tick();
    check_stat("brflush_done", 2'd0, 16'd2, 16'd1, 1'b0);

    // Memory wait with taken and load-use pending: full freeze for 3 cycles.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_ctrl("memwait", 4'b0000, 3'b000, 1'b0);
      tick();
    end
    check_stat("memwait", 2'd2, 16'd5, 16'd1, 1'b0);
    // Release in the same cycle mem_ready rises.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_ctrl("mem_release", 4'b1111, 3'b000, 1'b0);
    tick();
    check_stat("mem_release", 2'd0, 16'd5, 16'd1, 1'b0);

    // Timeout boundary via a stalled store: 254 cycles clear, 255th sets.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 254; i++) tick();
    check_stat("tmo_254", 2'd2, 16'd259, 16'd1, 1'b0);
    tick();
    check_stat("tmo_255", 2'd2, 16'd260, 16'd1, 1'b1);
    check_ctrl("tmo_frozen", 4'b0000, 3'b000, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_ctrl("tmo_release", 4'b1111, 3'b000, 1'b0);
    tick();
    tick();
    check_stat("tmo_sticky", 2'd0, 16'd260, 16'd1, 1'b1);

    // Reset in the middle of a memory wait.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_stat("pre_rst", 2'd2, 16'd262, 16'd1, 1'b1);
    reset = 1'b1;
    #1;
    check_ctrl("rst_wait", 4'b0000, 3'b111, 1'b0);
    tick();
    check_stat("rst_wait", 2'd0, 16'd0, 16'd0, 1'b0);
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_ctrl("post_rst", 4'b1111, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 Inputs: id_rs input 5 ID-stage source reg; id_rt input 5 ID-stage second source; id_uses_rt input 1 ID instruction reads rt.
REQ-003 Inputs: idex_MemRead input 1 EX-stage instruction is a load; idex_reg_dest input 5 EX-stage load destination.
REQ-004 Inputs: exmem_Branch input 1; exmem_zero input 1; exmem_MemRead input 1; exmem_MemWrite input 1 (MEM-stage controls); mem_ready input 1 data memory completes access this cycle.
REQ-005 Write-enable outputs: pc_write output 1; ifid_write output 1; idex_write output 1; exmem_write output 1 (pipeline register load enables).
REQ-006 Flush outputs: ifid_flush output 1; idex_flush output 1; exmem_flush output 1 (load zero controls, i.e. bubble); pc_src_branch output 1 select branch target.
REQ-007 Status outputs: state output 2; stall_count output 16; flush_count output 16; mem_timeout output 1 sticky error.
REQ-008 Parameter: MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before error.

Function
REQ-009 States SHALL be RUN=0, LOAD_STALL=1, MEM_WAIT=2, BR_FLUSH=3.
REQ-010 mem_busy SHALL be (exmem_MemRead|exmem_MemWrite)&~mem_ready; taken SHALL be exmem_Branch&exmem_zero; load_use SHALL be idex_MemRead & idex_reg_dest!=0 & (idex_reg_dest==id_rs | (id_uses_rt & idex_reg_dest==id_rt)).
REQ-011 Priority per cycle SHALL be mem_busy > taken > load_use > normal.
REQ-012 mem_busy: all four write enables 0, no flushes, pc_src_branch 0; next state MEM_WAIT.
REQ-013 taken (no mem_busy): all write enables 1, ifid_flush=idex_flush=exmem_flush=1, pc_src_branch=1; next state BR_FLUSH; flush_count += 1.
REQ-014 load_use (neither above): pc_write=ifid_write=0, idex_write=exmem_write=1, idex_flush=1; next state LOAD_STALL; stall_count += 1.
REQ-015 Normal: all write enables 1, all flushes 0, pc_src_branch 0; next state RUN.
REQ-016 In LOAD_STALL, load_use SHALL be ignored for exactly that cycle (bubble now in EX); other rules apply; a load_use stall is therefore exactly 1 cycle.
REQ-017 In BR_FLUSH, load_use SHALL be ignored (squashed instruction) for that cycle; other rules apply.
REQ-018 In MEM_WAIT, an internal wait counter SHALL increment each mem_busy cycle; reaching MEM_TIMEOUT sets mem_timeout=1 (sticky until reset) and the pipeline stays frozen; counter clears on leaving MEM_WAIT.
REQ-019 mem_busy deasserting in MEM_WAIT SHALL release the freeze the same cycle (Mealy outputs); stall_count increments once per frozen cycle.
REQ-020 stall_count and flush_count SHALL saturate at 16'hFFFF, not wrap.
REQ-021 state output SHALL show the registered state; all other control outputs SHALL be combinational from state and inputs.

Reset
REQ-022 While reset=1: all write enables 0, all flushes 1, pc_src_branch 0.
REQ-023 On a clock edge with reset=1: state RUN, both counters 0, wait counter 0, mem_timeout 0.
REQ-024 Reset asserted mid-stall, mid-wait or mid-flush SHALL abort it with no counter update that cycle.

Structure
REQ-025 State encodings and MEM_TIMEOUT default SHALL live in shared package pipeline_pkg.
REQ-026 The hazard comparator (REQ-010 load_use) SHALL be sub-module hazard_detect; FSM and counters SHALL be in the top.

Verification
REQ-027 idex_MemRead=1, idex_reg_dest=5, id_rs=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1, state LOAD_STALL next, stall_count=1, then RUN.
REQ-028 Same as 027 but idex_reg_dest=0 -> no stall, all write enables 1.
REQ-029 exmem_Branch=1, exmem_zero=1 -> pc_src_branch=1, three flushes 1, flush_count=1, state BR_FLUSH then RUN.
REQ-030 exmem_MemRead=1, mem_ready=0 for 3 cycles, load_use and taken also 1 -> all enables 0 three cycles, stall_count=3, no flush_count change.
REQ-031 mem_busy held 255 cycles (default) -> mem_timeout=1, stays 1 after mem_ready until reset.
REQ-032 reset=1 during MEM_WAIT -> next edge state RUN, counters 0, mem_timeout 0; flushes 1 while reset held.
